// File: rtl/bip_fetch_unit.sv
// bip_fetch_unit: fetch/sequencing stage upstream of the BIP instruction decoder.
// Owns the PC and the program-memory read handshake, holds the instruction in IR,
// and reports halt status plus a saturating run-cycle counter.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   i_start           level, sampled only in IDLE; starts a run at PC 0
//   i_enable_pc       from decoder: 1 = legal non-halting instruction in IR
//   o_pmem_addr       program-memory read address (always the PC)
//   o_pmem_rd         program-memory read strobe (FETCH only)
//   i_pmem_data       program-memory data, valid the cycle after o_pmem_rd
//   o_opcode          IR opcode field to decoder
//   o_operand         IR operand field to datapath
//   o_insn_valid      high in EXEC; gates all downstream write enables
//   o_pc              current PC
//   o_halted          high in HALT
//   o_cycle_count     cycles spent in FETCH/WAIT/EXEC, saturating
module bip_fetch_unit #(
  parameter int unsigned PC_WIDTH     = 11,
  parameter int unsigned INSN_WIDTH   = 16,
  parameter int unsigned OPCODE_WIDTH = 5,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic                             i_enable_pc,
  output logic [PC_WIDTH-1:0]              o_pmem_addr,
  output logic                             o_pmem_rd,
  input  logic [INSN_WIDTH-1:0]            i_pmem_data,
  output logic [OPCODE_WIDTH-1:0]          o_opcode,
  output logic [INSN_WIDTH-OPCODE_WIDTH-1:0] o_operand,
  output logic                             o_insn_valid,
  output logic [PC_WIDTH-1:0]              o_pc,
  output logic                             o_halted,
  output logic [CNT_WIDTH-1:0]             o_cycle_count
);

  localparam int unsigned OPERAND_WIDTH = INSN_WIDTH - OPCODE_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [INSN_WIDTH-1:0]   ir_q, ir_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    rd_q, valid_q, halted_q;

  // Next-state, PC, IR and counter update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Synchronous memory: read data is only valid in this cycle.
        ir_d    = i_pmem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (i_enable_pc) begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Count every running cycle, including the EXEC of the halting instruction.
    if ((state_q == S_FETCH || state_q == S_WAIT || state_q == S_EXEC) &&
        (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State register; status flags are registered from the next state so they
  // line up exactly with state_q without any decode after the flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      rd_q     <= (state_d == S_FETCH);
      valid_q  <= (state_d == S_EXEC);
      halted_q <= (state_d == S_HALT);
    end
  end

  assign o_pmem_addr   = pc_q;
  assign o_pc          = pc_q;
  assign o_pmem_rd     = rd_q;
  assign o_insn_valid  = valid_q;
  assign o_halted      = halted_q;
  assign o_cycle_count = cnt_q;
  assign o_opcode      = ir_q[INSN_WIDTH-1 -: OPCODE_WIDTH];
  assign o_operand     = ir_q[OPERAND_WIDTH-1:0];

endmodule

// File: tb/tb_bip_fetch_unit.sv
// Testbench for bip_fetch_unit: default-size instance (A) with scoreboard and
// decoder/memory models, plus a PC_WIDTH=2 / CNT_WIDTH=3 instance (B) for wrap
// and saturation.
module tb_bip_fetch_unit;

  typedef struct packed {
    logic [10:0] pc;
    logic [4:0]  op;
    logic [10:0] opd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [4:0] op);
    return (op >= 5'd1) && (op <= 5'd7);
  endfunction

  // ---------------- instance A (default parameters) ----------------
  logic        rst_a, start_a, en_a;
  logic [10:0] addr_a, pc_a;
  logic        rd_a, valid_a, halted_a;
  logic [15:0] pdata_a;
  logic [4:0]  op_a;
  logic [10:0] opd_a;
  logic [31:0] cnt_a;
  logic [15:0] mem_a [0:2047];

  bip_fetch_unit dut_a (
    .clk(clk), .rst(rst_a), .i_start(start_a), .i_enable_pc(en_a),
    .o_pmem_addr(addr_a), .o_pmem_rd(rd_a), .i_pmem_data(pdata_a),
    .o_opcode(op_a), .o_operand(opd_a), .o_insn_valid(valid_a),
    .o_pc(pc_a), .o_halted(halted_a), .o_cycle_count(cnt_a)
  );

  assign en_a = legal(op_a);

  // Synchronous BRAM model; garbage on non-read cycles.
  always @(posedge clk) begin
    if (rd_a) pdata_a <= mem_a[addr_a];
    else      pdata_a <= 16'($urandom);
  end

  exp_t        exp_q[$];
  int          exp_pcs[$];
  logic [10:0] fetch_q[$];
  int          exec_cnt = 0;
  int          last_valid = -1;

  // Monitor: records fetches, pops and checks every executed instruction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_a) begin
      last_valid = -1;
      exec_cnt   = 0;
    end else begin
      if (rd_a) fetch_q.push_back(addr_a);
      if (valid_a) begin
        exec_cnt++;
        if (last_valid >= 0) check("exec_spacing", 64'(cyc - last_valid), 64'd3);
        last_valid = cyc;
        check("exp_queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("exec_opcode", 64'(op_a), 64'(e.op));
          check("exec_operand", 64'(opd_a), 64'(e.opd));
          check("exec_pc", 64'(pc_a), 64'(e.pc));
        end
      end
    end
  end

  // Reference model: walk the program as the spec describes.
  task automatic model_a(output int n, output int hpc);
    int pc = 0;
    logic [15:0] w;
    exp_t e;
    n = 0;
    while (n < 4096) begin
      w = mem_a[pc];
      e.pc = 11'(pc); e.op = w[15:11]; e.opd = w[10:0];
      exp_q.push_back(e);
      exp_pcs.push_back(pc);
      n++;
      if (!legal(w[15:11])) break;
      pc = (pc + 1) % 2048;
    end
    hpc = pc;
  endtask

  task automatic clear_mem_a();
    for (int i = 0; i < 2048; i++) mem_a[i] = 16'h0000;
  endtask

  task automatic check_idle_zero_a(input string tag);
    check({tag, "_rd"}, 64'(rd_a), 64'd0);
    check({tag, "_valid"}, 64'(valid_a), 64'd0);
    check({tag, "_halted"}, 64'(halted_a), 64'd0);
    check({tag, "_pc"}, 64'(pc_a), 64'd0);
    check({tag, "_addr"}, 64'(addr_a), 64'd0);
    check({tag, "_count"}, 64'(cnt_a), 64'd0);
    check({tag, "_opcode"}, 64'(op_a), 64'd0);
    check({tag, "_operand"}, 64'(opd_a), 64'd0);
  endtask

  // Reset, load the scoreboard from the model, then pulse i_start.
  task automatic start_run_a(output int n, output int hpc);
    @(negedge clk);
    rst_a = 1'b1; start_a = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete(); exp_pcs.delete(); fetch_q.delete();
    model_a(n, hpc);
    rst_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic end_run_a(input string tag, input int n, input int hpc);
    int k = 0;
    while (!halted_a && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_halt_reached"}, 64'(halted_a), 64'd1);
    check({tag, "_final_pc"}, 64'(pc_a), 64'(hpc));
    check({tag, "_final_count"}, 64'(cnt_a), 64'(3 * n));
    check({tag, "_final_valid"}, 64'(valid_a), 64'd0);
    check({tag, "_scoreboard_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_exec_count"}, 64'(exec_cnt), 64'(n));
    check({tag, "_fetch_count"}, 64'(fetch_q.size()), 64'(n));
    for (int i = 0; i < n && i < fetch_q.size(); i++)
      check({tag, "_fetch_addr"}, 64'(fetch_q[i]), 64'(exp_pcs[i]));
  endtask

  // ---------------- instance B (PC_WIDTH=2, CNT_WIDTH=3) ----------------
  logic        rst_b, start_b, en_b;
  logic [1:0]  addr_b, pc_b;
  logic        rd_b, valid_b, halted_b;
  logic [15:0] pdata_b;
  logic [4:0]  op_b;
  logic [10:0] opd_b;
  logic [2:0]  cnt_b;
  logic [15:0] mem_b [0:3];

  bip_fetch_unit #(.PC_WIDTH(2), .INSN_WIDTH(16), .OPCODE_WIDTH(5), .CNT_WIDTH(3)) dut_b (
    .clk(clk), .rst(rst_b), .i_start(start_b), .i_enable_pc(en_b),
    .o_pmem_addr(addr_b), .o_pmem_rd(rd_b), .i_pmem_data(pdata_b),
    .o_opcode(op_b), .o_operand(opd_b), .o_insn_valid(valid_b),
    .o_pc(pc_b), .o_halted(halted_b), .o_cycle_count(cnt_b)
  );

  assign en_b = legal(op_b);

  always @(posedge clk) begin
    if (rd_b) pdata_b <= mem_b[addr_b];
    else      pdata_b <= 16'($urandom);
  end

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int n, hpc, k;
    logic [4:0]  op;
    logic [10:0] opd;
    logic [2:0]  sat;
    logic        exp_rd, exp_valid;

    rst_a = 1'b1; start_a = 1'b1;
    rst_b = 1'b1; start_b = 1'b0;

    // Directed program, with i_start held high through reset.
    clear_mem_a();
    mem_a[0] = 16'h1805;
    mem_a[1] = 16'h2803;
    mem_a[2] = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle_zero_a("reset_hold");
    end
    exp_q.delete(); exp_pcs.delete(); fetch_q.delete();
    model_a(n, hpc);
    rst_a = 1'b0;
    @(negedge clk);
    check("release_first_rd", 64'(rd_a), 64'd1);
    check("release_first_addr", 64'(addr_a), 64'd0);
    start_a = 1'b0;
    end_run_a("directed", n, hpc);
    check("directed_pc_const", 64'(pc_a), 64'd2);
    check("directed_count_const", 64'(cnt_a), 64'd9);
    check("directed_exec_const", 64'(exec_cnt), 64'd3);

    // Undefined opcode at address 1, then i_start toggling in HALT.
    clear_mem_a();
    mem_a[0] = 16'h1805;
    mem_a[1] = 16'hF800;
    mem_a[2] = 16'h1801;
    start_run_a(n, hpc);
    end_run_a("undef", n, hpc);
    check("undef_pc_const", 64'(pc_a), 64'd1);
    for (int i = 0; i < 6; i++) begin
      start_a = ~start_a;
      @(negedge clk);
      check("halt_toggle_rd", 64'(rd_a), 64'd0);
      check("halt_toggle_halted", 64'(halted_a), 64'd1);
    end
    start_a = 1'b0;
    check("halt_toggle_pc", 64'(pc_a), 64'd1);
    check("halt_toggle_count", 64'(cnt_a), 64'd6);
    check("halt_toggle_fetches", 64'(fetch_q.size()), 64'd2);

    // Reset during the WAIT of instruction 1.
    clear_mem_a();
    mem_a[0] = 16'h1805;
    mem_a[1] = 16'h2803;
    mem_a[2] = 16'h0000;
    start_run_a(n, hpc);
    k = 0;
    while (!(rd_a && addr_a == 11'd1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("midrun_fetch1_seen", 64'(rd_a && addr_a == 11'd1), 64'd1);
    @(posedge clk);
    #1 rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete(); exp_pcs.delete(); fetch_q.delete();
    check_idle_zero_a("midrun_reset");
    @(negedge clk);
    check_idle_zero_a("midrun_reset_hold");

    // Randomized programs.
    for (int t = 0; t < 10; t++) begin
      int len;
      clear_mem_a();
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        k = $urandom_range(0, 11);
        if (k == 0)      op = 5'd0;
        else if (k == 1) op = 5'($urandom_range(8, 31));
        else             op = 5'($urandom_range(1, 7));
        opd = 11'($urandom);
        mem_a[i] = {op, opd};
      end
      start_run_a(n, hpc);
      end_run_a("random", n, hpc);
    end

    // Instance B: PC wrap and counter saturation with a looping program.
    for (int i = 0; i < 4; i++) mem_b[i] = {5'($urandom_range(1, 7)), 11'($urandom)};
    @(negedge clk);
    check("b_reset_rd", 64'(rd_b), 64'd0);
    check("b_reset_count", 64'(cnt_b), 64'd0);
    rst_b = 1'b0; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int j = 0; j < 24; j++) begin
      sat       = (j > 7) ? 3'd7 : 3'(j);
      exp_rd    = (j % 3 == 0);
      exp_valid = (j % 3 == 2);
      check("b_pc", 64'(pc_b), 64'((j / 3) % 4));
      check("b_addr", 64'(addr_b), 64'((j / 3) % 4));
      check("b_rd", 64'(rd_b), 64'(exp_rd));
      check("b_valid", 64'(valid_b), 64'(exp_valid));
      check("b_count", 64'(cnt_b), 64'(sat));
      check("b_halted", 64'(halted_b), 64'd0);
      if (exp_valid) begin
        op = mem_b[(j / 3) % 4][15:11];
        check("b_opcode", 64'(op_b), 64'(op));
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
